// File: rtl/logbuf_ctrl.sv
// rtl/logbuf_ctrl.sv - CPU/hardware-requester arbiter writing 5-byte records into a log buffer.
// Optional LOGBUF_CTRL_OVERWRITE_EN: on full, overwrite the oldest entry instead of dropping.
module logbuf_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_ENTRIES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_stb,
  input  logic                    cpu_we,
  input  logic                    cpu_addr,
  input  logic [15:0]             cpu_din,
  output logic [31:0]             cpu_dout,
  output logic                    cpu_ack,
  output logic                    lb_stb,
  output logic                    lb_we,
  output logic                    lb_addr,
  output logic [15:0]             lb_din,
  input  logic [31:0]             lb_dout,
  input  logic                    lb_ack,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    busy,
  output logic [7:0]              drop_cnt
);
  typedef enum logic [1:0] {IDLE, RDIX, WRDATA, WRIX} state_t;
  localparam logic [7:0] IDX_MASK = 8'(NUM_ENTRIES - 1);

  state_t      state, state_nxt;
  logic [2:0]  rr_ptr, src_id, byte_cnt, arb_idx;
  logic        arb_hit, grant;
  logic [31:0] payload;
  logic [7:0]  put_idx, get_idx, next_put, new_get, rd_next_put, byte_val;
  logic        rd_full;
  int          j;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_ptr;
    j       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!arb_hit && req[j]) begin
        arb_hit = 1'b1;
        arb_idx = 3'(j);
      end
    end
  end

  assign grant       = (state == IDLE) && !cpu_stb && arb_hit;
  assign rd_next_put = (lb_dout[15:8] + 8'd1) & IDX_MASK;
  assign rd_full     = (rd_next_put == lb_dout[7:0]);
  assign next_put    = (put_idx + 8'd1) & IDX_MASK;
  assign busy        = (state != IDLE);

`ifdef LOGBUF_CTRL_OVERWRITE_EN
  logic full_q;
  assign full_q  = (next_put == get_idx);
  assign new_get = full_q ? ((get_idx + 8'd1) & IDX_MASK) : get_idx;
`else
  assign new_get = get_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = RDIX;
`ifdef LOGBUF_CTRL_OVERWRITE_EN
      RDIX:    state_nxt = WRDATA;
`else
      RDIX:    state_nxt = rd_full ? IDLE : WRDATA;
`endif
      WRDATA:  if (byte_cnt == 3'd4) state_nxt = WRIX;
      WRIX:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 3'(NUM_REQ - 1);
      src_id   <= '0;
      payload  <= '0;
      put_idx  <= '0;
      get_idx  <= '0;
      byte_cnt <= '0;
      drop_cnt <= '0;
      gnt      <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) gnt[i] <= grant && (i == int'(arb_idx));
      if (grant) begin
        rr_ptr  <= arb_idx;
        src_id  <= arb_idx;
        payload <= req_data[32*arb_idx +: 32];
      end
      if (state == RDIX) begin
        put_idx  <= lb_dout[15:8];
        get_idx  <= lb_dout[7:0];
        byte_cnt <= '0;
        if (rd_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (state == WRDATA) byte_cnt <= byte_cnt + 3'd1;
    end
  end

  always_comb begin
    case (byte_cnt)
      3'd0:    byte_val = 8'h80 | {5'b0, src_id};
      3'd1:    byte_val = payload[7:0];
      3'd2:    byte_val = payload[15:8];
      3'd3:    byte_val = payload[23:16];
      default: byte_val = payload[31:24];
    endcase
  end

  always_comb begin
    lb_stb   = 1'b0;
    lb_we    = 1'b0;
    lb_addr  = 1'b0;
    lb_din   = '0;
    cpu_dout = '0;
    cpu_ack  = 1'b0;
    case (state)
      IDLE: begin
        lb_stb   = cpu_stb;
        lb_we    = cpu_we;
        lb_addr  = cpu_addr;
        lb_din   = cpu_din;
        cpu_dout = lb_dout;
        cpu_ack  = lb_ack;
      end
      RDIX: begin
        lb_stb  = 1'b1;
        lb_addr = 1'b1;
      end
      WRDATA: begin
        lb_stb = 1'b1;
        lb_we  = 1'b1;
        lb_din = {8'h00, byte_val};
      end
      WRIX: begin
        lb_stb  = 1'b1;
        lb_we   = 1'b1;
        lb_addr = 1'b1;
        lb_din  = {next_put, new_get};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_logbuf_ctrl.sv
// tb/tb_logbuf_ctrl.sv - directed table-driven bench for logbuf_ctrl with a behavioral log buffer.
module tb_logbuf_ctrl;
  localparam int NR = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_stb = 0, cpu_we = 0, cpu_addr = 0;
  logic [15:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic        lb_stb, lb_we, lb_addr;
  logic [15:0] lb_din;
  logic [31:0] lb_dout;
  logic        lb_ack;
  logic [NR-1:0]    req = '0;
  logic [32*NR-1:0] req_data = '0;
  logic [NR-1:0]    gnt;
  logic        busy;
  logic [7:0]  drop_cnt;

  logic [15:0] lb_idx = 16'h0000;
  logic [16:0] wlog[$];
  int checks = 0, errors = 0;

  logbuf_ctrl #(.NUM_REQ(NR), .NUM_ENTRIES(32)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .lb_stb(lb_stb), .lb_we(lb_we),
    .lb_addr(lb_addr), .lb_din(lb_din), .lb_dout(lb_dout), .lb_ack(lb_ack), .req(req),
    .req_data(req_data), .gnt(gnt), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  assign lb_dout = lb_stb ? (lb_addr ? {16'h0000, lb_idx} : 32'hBEEF_0000) : 32'h0;
  assign lb_ack  = lb_stb;

  always @(negedge clk) if (rst_n && lb_stb && lb_we) wlog.push_back({lb_addr, lb_din});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    check(name, busy, 0);
  endtask

  task automatic run_rec(input logic [15:0] idx, input logic [3:0] r, input logic [31:0] pl,
                         output logic [3:0] g, output int bcnt);
    lb_idx = idx;
    wlog.delete();
    @(negedge clk);
    req = r;
    for (int i = 0; i < NR; i++) req_data[32*i +: 32] = r[i] ? pl : 32'hDEAD_BEEF;
    @(negedge clk);
    req = '0;
    g = gnt;
    bcnt = 0;
    while (busy && bcnt < 20) begin bcnt++; @(negedge clk); end
  endtask

  typedef struct {
    logic [15:0]      idx;
    logic [3:0]       r;
    logic [31:0]      pl;
    logic [3:0]       egnt;
    logic [4:0][7:0]  eb;
    logic [15:0]      eix;
    logic             full;
  } vec_t;

  vec_t tv[6];

  initial begin
    logic [3:0] g;
    int bc, nwr, exp_drop, ng, found, n;
    logic [3:0] order[$];
    logic wr;

    tv[0] = '{16'h0300, 4'b0100, 32'hA1B2C3D4, 4'b0100, {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h82}, 16'h0400, 1'b0};
    tv[1] = '{16'h1F05, 4'b0001, 32'h00000000, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h00, 8'h80}, 16'h0005, 1'b0};
    tv[2] = '{16'h1F00, 4'b1000, 32'h12345678, 4'b1000, {8'h12, 8'h34, 8'h56, 8'h78, 8'h83}, 16'h0001, 1'b1};
    tv[3] = '{16'h1011, 4'b0010, 32'hFFFFFFFF, 4'b0010, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h81}, 16'h1112, 1'b1};
    tv[4] = '{16'h0702, 4'b0010, 32'hCAFEBABE, 4'b0010, {8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h81}, 16'h0802, 1'b0};
    tv[5] = '{16'h1E1D, 4'b1000, 32'h0BADF00D, 4'b1000, {8'h0B, 8'hAD, 8'hF0, 8'h0D, 8'h83}, 16'h1F1D, 1'b0};

    // Reset state
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_lb_stb", lb_stb, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_lb_stb", lb_stb, 0);

    // Round-robin with all requesters held
    lb_idx = 16'h0005;
    req = 4'b1111;
    n = 0;
    while (order.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (gnt != 0) order.push_back(gnt);
    end
    req = '0;
    check("rr_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check($sformatf("rr_order_%0d", i), order[i], 4'b0001 << i);
    wait_idle("rr_idle");

    // Table of single records
    exp_drop = 0;
    for (int v = 0; v < 6; v++) begin
      run_rec(tv[v].idx, tv[v].r, tv[v].pl, g, bc);
      if (tv[v].full) exp_drop++;
`ifdef LOGBUF_CTRL_OVERWRITE_EN
      wr = 1'b1;
`else
      wr = !tv[v].full;
`endif
      nwr = wlog.size();
      check($sformatf("v%0d_gnt", v), g, tv[v].egnt);
      check($sformatf("v%0d_busy_cycles", v), bc, wr ? 7 : 1);
      check($sformatf("v%0d_drop", v), drop_cnt, exp_drop);
      check($sformatf("v%0d_nwrites", v), nwr, wr ? 6 : 0);
      if (wr && nwr == 6) begin
        for (int k = 0; k < 5; k++)
          check($sformatf("v%0d_byte%0d", v, k), wlog[k], {1'b0, 8'h00, tv[v].eb[k]});
        check($sformatf("v%0d_wrix", v), wlog[5], {1'b1, tv[v].eix});
      end
    end

    // CPU wins over a simultaneous request, pass-through in IDLE
    lb_idx = 16'h1234;
    @(negedge clk);
    cpu_stb = 1; cpu_we = 0; cpu_addr = 1;
    req = 4'b0001; req_data[31:0] = 32'h01020304;
    #1;
    check("cpu_ack_idle", cpu_ack, 1);
    check("cpu_dout_idle", cpu_dout, 32'h0000_1234);
    check("lb_addr_pass", {lb_stb, lb_we, lb_addr}, 3'b101);
    @(negedge clk);
    check("cpu_wins_gnt", gnt, 0);
    check("cpu_wins_busy", busy, 0);
    cpu_we = 1; cpu_din = 16'h5A5A; cpu_addr = 0;
    #1;
    check("cpu_wr_pass", {lb_stb, lb_we, lb_addr, lb_din}, {3'b110, 16'h5A5A});
    @(negedge clk);
    cpu_stb = 0; cpu_we = 0;
    @(negedge clk);
    check("gnt_after_cpu", gnt, 4'b0001);
    req = '0;
    @(negedge clk);
    cpu_stb = 1; cpu_addr = 0;
    #1;
    check("cpu_ack_busy", cpu_ack, 0);
    check("cpu_dout_busy", cpu_dout, 0);
    wait_idle("cpu_idle");
    #1;
    check("cpu_ack_after", cpu_ack, 1);
    check("cpu_dout_after", cpu_dout, 32'hBEEF_0000);
    @(negedge clk);
    cpu_stb = 0;

    // Drop counter saturation
    lb_idx = 16'h1F00;
    req = 4'b0001;
    ng = 0; n = 0;
    while (ng < 260 && n < 4000) begin
      @(negedge clk);
      n++;
      if (gnt != 0) ng++;
    end
    req = '0;
    check("sat_grants", ng, 260);
    wait_idle("sat_idle");
    check("sat_drop", drop_cnt, 255);

    // Reset in the middle of WRDATA byte 2
    lb_idx = 16'h0300;
    wlog.delete();
    @(negedge clk);
    req = 4'b0100; req_data[95:64] = 32'h55AA1133;
    @(negedge clk);
    req = '0;
    found = 0; n = 0;
    while (!found && n < 20) begin
      if (lb_stb && lb_we && !lb_addr && lb_din == 16'h0011) found = 1;
      else begin n++; @(negedge clk); end
    end
    check("mid_byte2_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lb_stb", lb_stb, 0);
    check("mid_rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n = 0;
    foreach (wlog[i]) if (wlog[i][16]) n++;
    check("mid_no_wrix", n, 0);
    req = 4'b1111;
    @(negedge clk);
    req = '0;
    check("mid_next_gnt", gnt, 4'b0001);
    wait_idle("mid_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
